dsi_pixel_reader: RTL
=====================

Name: dsi_pixel_reader

Overview:
- Read-side consumer of the first-word-fall-through asynchronous pixel FIFO in the DSI colorbar path.
- Runs on the FIFO read clock and generates the video timing: vs, hs and de.
- Pops one FIFO word per active pixel and presents it, registered and aligned to de, to the DSI packetiser.
- On FIFO underflow it substitutes a fill colour and records the event; it never stalls the raster.

Parameters:
- DW, 24, pixel / FIFO data width.
- H_SYNC, 2, hsync width in pixels.
- H_BP, 2, horizontal back porch.
- H_ACT, 8, active pixels per line.
- H_FP, 2, horizontal front porch.
- V_SYNC, 1, vsync width in lines.
- V_BP, 1, vertical back porch.
- V_ACT, 4, active lines per frame.
- V_FP, 1, vertical front porch.
- SYNC_POL, 1, asserted level of vs/hs.
- FILL_PIX, 24'hFF00FF, pixel emitted on underflow.

Ports:
- r_clk  in  1  read-domain clock; sole clock.
- r_clr  in  1  synchronous reset, active low.
- en  in  1  stream enable.
- fifo_data  in  DW  FWFT FIFO head word; valid while fifo_empty=0.
- fifo_empty  in  1  FIFO empty.
- fifo_re  out  1  pop strobe, combinational.
- vs  out  1  vertical sync.
- hs  out  1  horizontal sync.
- de  out  1  data enable.
- pix_data  out  DW  pixel aligned to de.
- underflow  out  1  sticky underflow flag.
- urun_cnt  out  16  underflow cycle count.
- flag_clr  in  1  clears underflow and urun_cnt.
- busy  out  1  high in RUN or DRAIN.

Behaviour:
- Reset (r_clr=0 sampled at a rising edge):
  - State IDLE; h_cnt=v_cnt=0.
  - vs=hs=~SYNC_POL; de=0; pix_data=0; underflow=0; urun_cnt=0; busy=0.
  - fifo_re=0 in the same cycle.
  - Reset mid-frame aborts immediately; there is no drain.
- Widths: H_TOTAL=H_SYNC+H_BP+H_ACT+H_FP and V_TOTAL likewise for the vertical terms.
- Counters:
  - h_cnt counts 0..H_TOTAL-1.
  - v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1.
  - Both counters run only in RUN and DRAIN; they are held at 0 otherwise.
- Raster decode:
  - hs_n = h_cnt<H_SYNC.
  - vs_n = v_cnt<V_SYNC.
  - act_n = (H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACT) and the same test on v_cnt.
- State machine (IDLE, PRIME, RUN, DRAIN):
  - IDLE: en=1 -> PRIME.
  - PRIME: en=0 -> IDLE; fifo_empty=0 -> RUN, starting at h=v=0 on the next cycle. This guarantees at least the first word is present.
  - RUN: en=0 -> DRAIN; the current frame is finished.
  - DRAIN: en=1 -> RUN with no raster gap. At the last position (h=H_TOTAL-1, v=V_TOTAL-1) with en=0 -> IDLE.
- Pop and output path:
  - fifo_re = (RUN|DRAIN) & act_n & ~fifo_empty.
  - At most one pop per cycle; no pop occurs outside active positions.
- Output latency is 1 cycle from the counter position. Registered each cycle:
  - vs <= vs_n?SYNC_POL:~SYNC_POL (hs likewise from hs_n).
  - de <= act_n.
  - pix_data <= act_n ? (fifo_empty ? FILL_PIX : fifo_data) : 0.
  - Outside RUN/DRAIN all outputs hold their reset values.
- Underflow:
  - Occurs on any cycle with (RUN|DRAIN) & act_n & fifo_empty.
  - Sets underflow and increments urun_cnt, saturating at 16'hFFFF.
  - If flag_clr and an underflow event occur in the same cycle, the event wins: underflow=1, urun_cnt=1.
  - The raster never stops on underflow; the line count is preserved.

Test Plan:
- Reset, en=0, FIFO full -> fifo_re never asserts; vs=hs=0, de=0, busy=0 for 100 cycles.
- Preload 32 words (values 0..31), en=1 -> first de one cycle after the cycle where h_cnt=4, v_cnt=2.
  - pix_data sequence is 0..7 on line 0 and 8..15 on line 1.
  - Exactly 8 pops per active line, 32 per frame (H_TOTAL=14, V_TOTAL=7, 98 cycles per frame).
  - underflow stays 0.
- Preload 5 words, en=1 -> pixels 0..4 followed by FILL_PIX for 27 active pixels.
  - urun_cnt=27 and underflow=1 at frame end.
  - hs and vs cadence is unchanged.
- Drop en mid-frame at h=6, v=3 -> raster completes to h=13, v=6, then busy=0 and outputs go idle.
  - Re-asserting en during DRAIN continues into the next frame without a gap.
- Assert r_clr=0 mid-active-line -> next cycle de=0, fifo_re=0, counters 0, urun_cnt=0.
  - After release with en=1 and a non-empty FIFO, the raster restarts from h=v=0.
- Hold flag_clr=1 through an underflow cycle -> underflow=1 and urun_cnt=1 afterwards.
  - A flag_clr pulse with no further underflow -> both clear to 0.

Source files
------------

// File: rtl/dsi_pixel_reader.sv
// dsi_pixel_reader: drains a FWFT pixel FIFO into a vs/hs/de raster with registered pixel output, fill colour and sticky underflow count on starvation
module dsi_pixel_reader #(
  parameter int DW = 24,
  parameter int H_SYNC = 2,
  parameter int H_BP = 2,
  parameter int H_ACT = 8,
  parameter int H_FP = 2,
  parameter int V_SYNC = 1,
  parameter int V_BP = 1,
  parameter int V_ACT = 4,
  parameter int V_FP = 1,
  parameter logic SYNC_POL = 1'b1,
  parameter logic [DW-1:0] FILL_PIX = 24'hFF00FF
) (
  input  logic          r_clk,
  input  logic          r_clr,
  input  logic          en,
  input  logic [DW-1:0] fifo_data,
  input  logic          fifo_empty,
  output logic          fifo_re,
  output logic          vs,
  output logic          hs,
  output logic          de,
  output logic [DW-1:0] pix_data,
  output logic          underflow,
  output logic [15:0]   urun_cnt,
  input  logic          flag_clr,
  output logic          busy
);
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  typedef enum logic [1:0] {IDLE, PRIME, RUN, DRAIN} state_t;
  state_t state;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic run, h_last, v_last, last, hs_n, vs_n, act_n, uf;
  always_comb begin
    run = state == RUN || state == DRAIN;
    h_last = h_cnt == HW'(H_TOTAL - 1);
    v_last = v_cnt == VW'(V_TOTAL - 1);
    last = h_last && v_last;
    hs_n = h_cnt < HW'(H_SYNC);
    vs_n = v_cnt < VW'(V_SYNC);
    act_n = h_cnt >= HW'(H_SYNC + H_BP) && h_cnt < HW'(H_SYNC + H_BP + H_ACT) &&
            v_cnt >= VW'(V_SYNC + V_BP) && v_cnt < VW'(V_SYNC + V_BP + V_ACT);
    uf = run && act_n && fifo_empty;
    fifo_re = r_clr && run && act_n && !fifo_empty;
    busy = run;
  end
  always_ff @(posedge r_clk) begin
    if (!r_clr) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
      vs <= ~SYNC_POL;
      hs <= ~SYNC_POL;
      de <= 1'b0;
      pix_data <= '0;
      underflow <= 1'b0;
      urun_cnt <= '0;
    end else begin
      state <= run ? (en ? RUN : last ? IDLE : DRAIN) :
               state == PRIME ? (!en ? IDLE : !fifo_empty ? RUN : PRIME) :
               en ? PRIME : IDLE;
      h_cnt <= run && !h_last ? h_cnt + HW'(1) : '0;
      v_cnt <= !run ? '0 : h_last ? (v_last ? '0 : v_cnt + VW'(1)) : v_cnt;
      vs <= run && vs_n ? SYNC_POL : ~SYNC_POL;
      hs <= run && hs_n ? SYNC_POL : ~SYNC_POL;
      de <= run && act_n;
      pix_data <= run && act_n ? (fifo_empty ? FILL_PIX : fifo_data) : '0;
      underflow <= uf || (underflow && !flag_clr);
      urun_cnt <= uf ? (flag_clr ? 16'd1 : urun_cnt + {15'd0, urun_cnt != 16'hFFFF}) :
                  flag_clr ? '0 : urun_cnt;
    end
  end
endmodule
